// File: rtl/booth8_pkg.sv
// Shared types and helpers for the radix-8 Booth multiply engine.
package booth8_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRE3M,
    ITER,
    DONE
  } state_e;

  // Magnitude of the current Booth digit: which multiple of M to add.
  typedef enum logic [2:0] {
    SEL_0,
    SEL_1M,
    SEL_2M,
    SEL_3M,
    SEL_4M
  } sel_e;

  // Radix-8 digits needed to cover a W=n+1 bit operand: ceil((n+1)/3).
  function automatic int unsigned num_digits(input int unsigned n);
    return (n + 3) / 3;
  endfunction

endpackage

// File: rtl/booth8_digit_decode.sv
// Radix-8 Booth recoder: 4-bit overlapping multiplier window to magnitude select and sign.
module booth8_digit_decode
  import booth8_pkg::*;
(
  input  logic [3:0] window,
  output sel_e       sel,
  output logic       neg
);

  always_comb begin
    sel = SEL_0;
    // Negative digit whenever the top bit is set, except the all-ones window (digit 0).
    neg = window[3] & ~(&window[2:0]);
    case (window)
      4'b0000, 4'b1111:                   sel = SEL_0;
      4'b0001, 4'b0010, 4'b1101, 4'b1110: sel = SEL_1M;
      4'b0011, 4'b0100, 4'b1011, 4'b1100: sel = SEL_2M;
      4'b0101, 4'b0110, 4'b1001, 4'b1010: sel = SEL_3M;
      4'b0111, 4'b1000:                   sel = SEL_4M;
      default:                            sel = SEL_0;
    endcase
  end

endmodule

// File: rtl/booth8_engine.sv
// Radix-8 Booth multiply engine: one digit per cycle into a signed 2W-bit product.
// Optional write-back of the product low word to memblock slot C: BOOTH8_WRITEBACK_EN.
module booth8_engine
  import booth8_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic           Clock,
  input  logic           Reset_n,
  input  logic           Start,
  input  logic [N:0]     A_Data,
  input  logic [N:0]     B_Data,
  output logic           Busy,
  output logic           Done,
  output logic [2*N+1:0] Product,
  output logic [N:0]     C_In,
  output logic           C_En
);

  localparam int unsigned W  = N + 1;
  localparam int unsigned D  = num_digits(N);
  localparam int unsigned QW = 3 * D;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = $clog2(D + 1);

  state_e          state;
  logic [PW-1:0]   m;
  logic [PW-1:0]   m3;
  logic [PW-1:0]   acc;
  logic [QW:0]     q_sh;  // {sign-extended Q, q[-1]}, shifted right 3 per digit
  logic [CW-1:0]   cnt;
  sel_e            sel;
  logic            neg;
  logic [PW-1:0]   mag;
  logic [PW-1:0]   term;
  logic [PW-1:0]   sum;
  logic            last_digit;

  booth8_digit_decode u_decode (
    .window (q_sh[3:0]),
    .sel    (sel),
    .neg    (neg)
  );

  // m and m3 are pre-shifted by 3i, so the digit multiple needs no variable shift.
  always_comb begin
    mag = '0;
    case (sel)
      SEL_0:   mag = '0;
      SEL_1M:  mag = m;
      SEL_2M:  mag = m << 1;
      SEL_3M:  mag = m3;
      SEL_4M:  mag = m << 2;
      default: mag = '0;
    endcase
    term       = neg ? -mag : mag;
    sum        = acc + term;
    last_digit = (state == ITER) && (cnt == CW'(D - 1));
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Product <= '0;
      m       <= '0;
      m3      <= '0;
      acc     <= '0;
      q_sh    <= '0;
      cnt     <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state <= LOAD;
            Busy  <= 1'b1;
          end
        end
        LOAD: begin
          m     <= PW'(signed'(A_Data));
          q_sh  <= {QW'(signed'(B_Data)), 1'b0};
          acc   <= '0;
          cnt   <= '0;
          state <= PRE3M;
        end
        PRE3M: begin
          m3    <= m + (m << 1);
          state <= ITER;
        end
        ITER: begin
          acc  <= sum;
          m    <= m << 3;
          m3   <= m3 << 3;
          q_sh <= $signed(q_sh) >>> 3;
          if (last_digit) begin
            Product <= sum;
            Done    <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BOOTH8_WRITEBACK_EN
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      C_In <= '0;
      C_En <= 1'b0;
    end else begin
      C_En <= last_digit;
      if (last_digit) C_In <= sum[N:0];
    end
  end
`else
  assign C_In = '0;
  assign C_En = 1'b0;
`endif

endmodule

// File: tb/tb_booth8_engine.sv
// Scoreboard bench for booth8_engine (N=8): directed operands with hand-computed products.
module tb_booth8_engine;

  localparam int unsigned N = 8;

  logic           Clock   = 1'b0;
  logic           Reset_n = 1'b0;
  logic           Start   = 1'b0;
  logic [N:0]     A_Data  = '0;
  logic [N:0]     B_Data  = '0;
  logic           Busy;
  logic           Done;
  logic [2*N+1:0] Product;
  logic [N:0]     C_In;
  logic           C_En;

  booth8_engine #(.N(N)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Start   (Start),
    .A_Data  (A_Data),
    .B_Data  (B_Data),
    .Busy    (Busy),
    .Done    (Done),
    .Product (Product),
    .C_In    (C_In),
    .C_En    (C_En)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int dones    = 0;
  int busy_cnt = 0;
  logic [17:0] exp_q[$];
  int          start_q[$];
  logic [17:0] e_mon;
  int          s_mon;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports Done.
  always @(negedge Clock) begin
    if (!Reset_n) begin
      busy_cnt = 0;
    end else begin
      if (Busy && !Done) busy_cnt++;
      else if (!Busy) busy_cnt = 0;
      if (Done) begin
        dones++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e_mon = exp_q.pop_front();
          s_mon = start_q.pop_front();
          check("product", 32'(Product), 32'(e_mon));
          check("latency", 32'(cyc - s_mon), 32'd6);
          check("busy_cycles", 32'(busy_cnt), 32'd5);
`ifdef BOOTH8_WRITEBACK_EN
          check("c_en_done", 32'(C_En), 32'd1);
          check("c_in_done", 32'(C_In), 32'(e_mon[8:0]));
`else
          check("c_en_done", 32'(C_En), 32'd0);
          check("c_in_done", 32'(C_In), 32'd0);
`endif
        end
        busy_cnt = 0;
      end else begin
        check("c_en_idle", 32'(C_En), 32'd0);
      end
    end
  end

  task automatic wait_dones(input int target);
    int n = 0;
    while (dones < target && n < 40) begin
      @(posedge Clock);
      n++;
    end
    if (dones < target) check("done_timeout", 32'(dones), 32'(target));
  endtask

  task automatic issue(input int a, input int b, input int p);
    int d0;
    d0 = dones;
    @(posedge Clock); #1;
    A_Data = 9'(a);
    B_Data = 9'(b);
    Start  = 1'b1;
    exp_q.push_back(18'(p));
    start_q.push_back(cyc);
    @(posedge Clock); #1;
    Start = 1'b0;
    wait_dones(d0 + 1);
    @(posedge Clock); #1;
    check("busy_after_done", 32'(Busy), 32'd0);
  endtask

  initial begin
    int d0;
    #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_product", 32'(Product), 32'd0);
    check("rst_c_en", 32'(C_En), 32'd0);
    check("rst_c_in", 32'(C_In), 32'd0);
    @(posedge Clock); @(posedge Clock); #1;
    Reset_n = 1'b1;

    issue(3, 5, 15);
    issue(-7, 9, -63);
    issue(-256, -256, 65536);
    issue(255, -256, -65280);
    issue(0, -1, 0);
    issue(1, -1, -1);
    issue(-1, -1, 1);
    issue(100, -3, -300);

    // Start and A_Data disturbed during ITER: ignored, original operands used.
    d0 = dones;
    @(posedge Clock); #1;
    A_Data = 9'(12); B_Data = 9'(-11); Start = 1'b1;
    exp_q.push_back(18'(-132));
    start_q.push_back(cyc);
    @(posedge Clock); #1; Start = 1'b0;
    @(posedge Clock); #1;
    @(posedge Clock); #1; Start = 1'b1; A_Data = 9'h055;
    @(posedge Clock); #1; Start = 1'b0;
    wait_dones(d0 + 1);
    repeat (10) @(posedge Clock);
    #1;
    check("single_done", 32'(dones - d0), 32'd1);

    // Start held high re-triggers from IDLE: one result every 7 cycles.
    d0 = dones;
    @(posedge Clock); #1;
    A_Data = 9'(-128); B_Data = 9'(127); Start = 1'b1;
    exp_q.push_back(18'(-16256));
    start_q.push_back(cyc);
    exp_q.push_back(18'(-16256));
    start_q.push_back(cyc + 7);
    repeat (8) @(posedge Clock);
    #1; Start = 1'b0;
    wait_dones(d0 + 2);
    repeat (10) @(posedge Clock);
    #1;
    check("held_start_dones", 32'(dones - d0), 32'd2);

    // Reset during ITER aborts with no Done.
    @(posedge Clock); #1;
    A_Data = 9'(50); B_Data = 9'(50); Start = 1'b1;
    @(posedge Clock); #1; Start = 1'b0;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    d0 = dones;
    Reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_product", 32'(Product), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    @(posedge Clock); @(posedge Clock); #1;
    Reset_n = 1'b1;
    repeat (10) @(posedge Clock);
    #1;
    check("abort_no_done", 32'(dones - d0), 32'd0);
    issue(-7, 9, -63);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
